// File: rtl/ac_axis_tx.sv
// AXI4-Stream transmit stage: drains the access-control output buffer with VDMA framing.
// Define AC_AXIS_TKEEP_EN to add the m_axis_tkeep output for a partially padded last beat.
module ac_axis_tx #(
    parameter int UPSP_WRTDATA_WIDTH = 24,
    parameter int N_PARALLEL         = 2,
    parameter int DST_IMG_WIDTH      = 4096,
    parameter int DST_IMG_HEIGHT     = 2160
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [UPSP_WRTDATA_WIDTH*N_PARALLEL-1:0]   buf_rdata,
    input  logic                                       buf_empty,
    output logic                                       buf_rd,
    output logic [UPSP_WRTDATA_WIDTH*N_PARALLEL-1:0]   m_axis_tdata,
    output logic                                       m_axis_tvalid,
    input  logic                                       m_axis_tready,
    output logic                                       m_axis_tlast,
    output logic                                       m_axis_tuser,
    output logic                                       frame_done
`ifdef AC_AXIS_TKEEP_EN
    ,
    output logic [UPSP_WRTDATA_WIDTH*N_PARALLEL/8-1:0] m_axis_tkeep
`endif
);

    localparam int W             = UPSP_WRTDATA_WIDTH;
    localparam int N_UPSP_WRT    = W / 24;
    localparam int AXIS_W        = W * N_PARALLEL;
    localparam int N_PKG         = DST_IMG_WIDTH / N_UPSP_WRT;
    localparam int BEATS_PER_ROW = (N_PKG + N_PARALLEL - 1) / N_PARALLEL;
    localparam int CW            = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
    localparam int RW            = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(BEATS_PER_ROW - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(DST_IMG_HEIGHT - 1);

    logic [AXIS_W-1:0] r_qData [2];
    logic [1:0]        r_qLast;
    logic [1:0]        r_qUser;
    logic [1:0]        r_occ;
    logic              r_inf;
    logic              r_active;
    logic              r_frameDone;
    logic [CW-1:0]     r_enqCol;
    logic [RW-1:0]     r_enqRow;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;

    logic              w_pop;
    logic [2:0]        w_level;
    logic              w_wrIdx;
    logic              w_enqLast;
    logic              w_enqUser;
    logic [AXIS_W-1:0] w_reord;

    // Earliest pixel sits in the top lane of the buffer word; move it to lane 0.
    for (genvar j = 0; j < N_PARALLEL; j++) begin : g_lane
        assign w_reord[j*W +: W] = buf_rdata[(N_PARALLEL-1-j)*W +: W];
    end

    always_comb begin
        w_pop   = (r_occ != 2'd0) & m_axis_tready;
        w_level = {1'b0, r_occ} + {2'b00, r_inf} - {2'b00, w_pop};
        w_wrIdx = w_pop ? (r_occ == 2'd2) : (r_occ == 2'd1);
    end

    assign w_enqLast = (r_enqCol == LAST_COL);
    assign w_enqUser = (r_enqCol == '0) && (r_enqRow == '0);

    // r_active holds off reads until the first edge after reset release.
    assign buf_rd        = r_active & ~buf_empty & (w_level < 3'd2);
    assign m_axis_tvalid = (r_occ != 2'd0);
    assign m_axis_tdata  = r_qData[0];
    assign m_axis_tlast  = r_qLast[0];
    assign m_axis_tuser  = r_qUser[0];
    assign frame_done    = r_frameDone;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qData[0] <= '0;
            r_qData[1] <= '0;
            r_qLast    <= '0;
            r_qUser    <= '0;
            r_occ      <= '0;
            r_inf      <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_active <= 1'b1;
            r_inf    <= buf_rd;
            r_occ    <= r_occ + {1'b0, r_inf} - {1'b0, w_pop};
            if (w_pop) begin
                r_qData[0] <= r_qData[1];
                r_qLast[0] <= r_qLast[1];
                r_qUser[0] <= r_qUser[1];
            end
            // The returning word lands behind any entry that survives this cycle's pop.
            if (r_inf) begin
                r_qData[w_wrIdx] <= w_reord;
                r_qLast[w_wrIdx] <= w_enqLast;
                r_qUser[w_wrIdx] <= w_enqUser;
            end
        end
    end

    // Enqueue-side position decides the sideband bits carried with each word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enqCol <= '0;
            r_enqRow <= '0;
        end else if (r_inf) begin
            if (w_enqLast) begin
                r_enqCol <= '0;
                r_enqRow <= (r_enqRow == LAST_ROW) ? '0 : r_enqRow + 1'b1;
            end else begin
                r_enqCol <= r_enqCol + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= w_pop && (r_col == LAST_COL) && (r_row == LAST_ROW);
            if (w_pop) begin
                if (r_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

`ifdef AC_AXIS_TKEEP_EN
    localparam int KW  = AXIS_W / 8;
    localparam int REM = N_PKG % N_PARALLEL;
    localparam logic [KW-1:0] KEEP_LAST =
        (REM == 0) ? {KW{1'b1}} : ({KW{1'b1}} >> (KW - REM * W / 8));

    logic [KW-1:0] r_qKeep [2];

    assign m_axis_tkeep = r_qKeep[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qKeep[0] <= '0;
            r_qKeep[1] <= '0;
        end else begin
            if (w_pop) begin
                r_qKeep[0] <= r_qKeep[1];
            end
            if (r_inf) begin
                r_qKeep[w_wrIdx] <= w_enqLast ? KEEP_LAST : {KW{1'b1}};
            end
        end
    end
`endif

endmodule

// File: tb/tb_ac_axis_tx.sv
// Directed testbench for ac_axis_tx: framing, lane order, back-pressure, in-flight reads, reset.
// A second instance (4 lanes, 10-pixel rows) covers the padded last beat and, with AC_AXIS_TKEEP_EN, tkeep.
`timescale 1ns/1ps
module tb_ac_axis_tx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int assertions = 0;
    int failures   = 0;

    logic [47:0] bufRdata = '0;
    logic        bufEmpty;
    logic        bufRd;
    logic [47:0] tdata;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        tlast;
    logic        tuser;
    logic        frameDone;

    logic [95:0] bufRdataB = '0;
    logic        bufEmptyB;
    logic        bufRdB;
    logic [95:0] tdataB;
    logic        tvalidB;
    logic        treadyB = 1'b1;
    logic        tlastB;
    logic        tuserB;
    logic        frameDoneB;
`ifdef AC_AXIS_TKEEP_EN
    logic [5:0]  tkeep;
    logic [11:0] tkeepB;
`endif

    ac_axis_tx #(.UPSP_WRTDATA_WIDTH(24), .N_PARALLEL(2), .DST_IMG_WIDTH(12), .DST_IMG_HEIGHT(2)) dut (
        .clk(clk), .rst_n(rst_n), .buf_rdata(bufRdata), .buf_empty(bufEmpty), .buf_rd(bufRd),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .m_axis_tuser(tuser), .frame_done(frameDone)
`ifdef AC_AXIS_TKEEP_EN
        , .m_axis_tkeep(tkeep)
`endif
    );

    ac_axis_tx #(.UPSP_WRTDATA_WIDTH(24), .N_PARALLEL(4), .DST_IMG_WIDTH(10), .DST_IMG_HEIGHT(1)) dutB (
        .clk(clk), .rst_n(rst_n), .buf_rdata(bufRdataB), .buf_empty(bufEmptyB), .buf_rd(bufRdB),
        .m_axis_tdata(tdataB), .m_axis_tvalid(tvalidB), .m_axis_tready(treadyB),
        .m_axis_tlast(tlastB), .m_axis_tuser(tuserB), .frame_done(frameDoneB)
`ifdef AC_AXIS_TKEEP_EN
        , .m_axis_tkeep(tkeepB)
`endif
    );

    // Buffer models: FIFO with one-cycle read latency; forceEmpty masks words already pushed.
    logic [47:0] memA [0:255];
    logic [7:0]  pushIdx = '0;
    logic [7:0]  popIdx  = '0;
    logic        forceEmpty = 1'b0;
    assign bufEmpty = (pushIdx == popIdx) || forceEmpty;
    always @(posedge clk) begin
        if (bufRd) begin
            bufRdata <= memA[popIdx];
            popIdx   <= popIdx + 8'd1;
        end
    end

    logic [95:0] memB [0:15];
    logic [3:0]  pushIdxB = '0;
    logic [3:0]  popIdxB  = '0;
    assign bufEmptyB = (pushIdxB == popIdxB);
    always @(posedge clk) begin
        if (bufRdB) begin
            bufRdataB <= memB[popIdxB];
            popIdxB   <= popIdxB + 4'd1;
        end
    end

    // Beat recorder for the main instance, sampled on the falling edge.
    int          cyc    = 0;
    int          rxCnt  = 0;
    int          fdCnt  = 0;
    int          fdCyc  = 0;
    logic [47:0] rxData [0:255];
    logic        rxLast [0:255];
    logic        rxUser [0:255];
    int          rxCyc  [0:255];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tvalid && tready) begin
            rxData[rxCnt[7:0]] <= tdata;
            rxLast[rxCnt[7:0]] <= tlast;
            rxUser[rxCnt[7:0]] <= tuser;
            rxCyc[rxCnt[7:0]]  <= cyc;
            rxCnt <= rxCnt + 1;
        end
        if (frameDone) begin
            fdCnt <= fdCnt + 1;
            fdCyc <= cyc;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [47:0] swap2(input logic [47:0] w);
        return {w[23:0], w[47:24]};
    endfunction

    function automatic logic [95:0] swap4(input logic [95:0] w);
        return {w[23:0], w[47:24], w[71:48], w[95:72]};
    endfunction

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushA(input logic [47:0] w);
        memA[pushIdx] = w;
        pushIdx = pushIdx + 8'd1;
    endtask

    task automatic waitBeats(input int target, input int budget);
        for (int c = 0; c < budget && rxCnt < target; c++) stepCycles(1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        pushA(48'h123456_789ABC);
        stepCycles(3);
        assertions++;
        if (bufRd !== 1'b0) begin failures++; $display("[TB] FAIL reset_buf_rd: got %b expected 0", bufRd); end
        assertions++;
        if (tvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_tvalid: got %b expected 0", tvalid); end
        assertions++;
        if (tdata !== 48'h0) begin failures++; $display("[TB] FAIL reset_tdata: got %h expected 0", tdata); end
        assertions++;
        if ({tlast, tuser, frameDone} !== 3'b000) begin
            failures++; $display("[TB] FAIL reset_sideband: got %b expected 000", {tlast, tuser, frameDone});
        end
        assertions++;
        if (popIdx !== 8'd0) begin failures++; $display("[TB] FAIL reset_no_pop: got %0d pops expected 0", popIdx); end
`ifdef AC_AXIS_TKEEP_EN
        assertions++;
        if (tkeep !== 6'h00) begin failures++; $display("[TB] FAIL reset_tkeep: got %h expected 00", tkeep); end
`endif
        pushIdx = popIdx;
        rst_n = 1'b1;
        stepCycles(2);
    endtask

    task automatic test_basic_frame;
        int start;
        int fd0;
        logic [47:0] w [12];
        start = rxCnt;
        fd0   = fdCnt;
        tready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            w[i] = {4'hC, 20'(i), 4'h3, 20'(i + 100)};
            pushA(w[i]);
        end
        for (int c = 0; c < 50 && (rxCnt < start + 12 || fdCnt == fd0); c++) stepCycles(1);
        assertions++;
        if (rxCnt - start !== 12) begin failures++; $display("[TB] FAIL basic_count: got %0d beats expected 12", rxCnt - start); end
        for (int k = 0; k < 12; k++) begin
            assertions++;
            if (rxData[start + k] !== swap2(w[k]) || rxUser[start + k] !== (k == 0) || rxLast[start + k] !== (k % 6 == 5)) begin
                failures++;
                $display("[TB] FAIL basic_beat[%0d]: got data=%h user=%b last=%b expected data=%h user=%b last=%b",
                         k, rxData[start + k], rxUser[start + k], rxLast[start + k], swap2(w[k]), k == 0, k % 6 == 5);
            end
            if (k > 0) begin
                assertions++;
                if (rxCyc[start + k] !== rxCyc[start + k - 1] + 1) begin
                    failures++;
                    $display("[TB] FAIL basic_gap[%0d]: got cycle %0d expected %0d", k, rxCyc[start + k], rxCyc[start + k - 1] + 1);
                end
            end
        end
        assertions++;
        if (fdCnt !== fd0 + 1 || fdCyc !== rxCyc[start + 11] + 1) begin
            failures++;
            $display("[TB] FAIL basic_frame_done: got count=%0d cycle=%0d expected count=%0d cycle=%0d",
                     fdCnt - fd0, fdCyc, 1, rxCyc[start + 11] + 1);
        end
    endtask

    task automatic test_back_pressure;
        int start;
        int fd0;
        logic [15:0] lfsr;
        logic        prevStall;
        logic [49:0] prevBeat;
        logic [47:0] w [24];
        start = rxCnt;
        fd0   = fdCnt;
        lfsr  = 16'hACE1;
        prevStall = 1'b0;
        prevBeat  = '0;
        for (int i = 0; i < 24; i++) begin
            w[i] = {8'h5A, 16'(i * 7 + 3), 8'hA5, 16'(i * 13 + 1)};
            pushA(w[i]);
        end
        for (int c = 0; c < 400 && rxCnt < start + 24; c++) begin
            tready = lfsr[0] ^ lfsr[5];
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            @(negedge clk);
            if (prevStall) begin
                assertions++;
                if (tvalid !== 1'b1 || {tdata, tlast, tuser} !== prevBeat) begin
                    failures++;
                    $display("[TB] FAIL bp_stable: got valid=%b beat=%h expected valid=1 beat=%h", tvalid, {tdata, tlast, tuser}, prevBeat);
                end
            end
            assertions++;
            if (dut.r_occ > 2'd2) begin failures++; $display("[TB] FAIL bp_occ: got %0d expected <= 2", dut.r_occ); end
            prevStall = tvalid && !tready;
            prevBeat  = {tdata, tlast, tuser};
            @(posedge clk);
            #1;
        end
        tready = 1'b1;
        stepCycles(3);
        assertions++;
        if (rxCnt - start !== 24) begin failures++; $display("[TB] FAIL bp_count: got %0d beats expected 24", rxCnt - start); end
        for (int k = 0; k < 24; k++) begin
            assertions++;
            if (rxData[start + k] !== swap2(w[k]) || rxUser[start + k] !== (k % 12 == 0) || rxLast[start + k] !== (k % 6 == 5)) begin
                failures++;
                $display("[TB] FAIL bp_beat[%0d]: got data=%h user=%b last=%b expected data=%h user=%b last=%b",
                         k, rxData[start + k], rxUser[start + k], rxLast[start + k], swap2(w[k]), k % 12 == 0, k % 6 == 5);
            end
        end
        assertions++;
        if (fdCnt - fd0 !== 2) begin failures++; $display("[TB] FAIL bp_frame_done: got %0d pulses expected 2", fdCnt - fd0); end
    endtask

    task automatic test_lane_reorder;
        int start;
        start = rxCnt;
        pushA(48'hAAAAAA_BBBBBB);
        waitBeats(start + 1, 20);
        assertions++;
        if (rxData[start] !== 48'hBBBBBB_AAAAAA || rxUser[start] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reorder: got data=%h user=%b expected data=bbbbbbaaaaaa user=1", rxData[start], rxUser[start]);
        end
    endtask

    task automatic test_empty_in_flight;
        int start;
        int rdSeen;
        start = rxCnt;
        pushA(48'h111111_222222);
        @(negedge clk);
        assertions++;
        if (bufRd !== 1'b1) begin failures++; $display("[TB] FAIL inflight_rd: got %b expected 1", bufRd); end
        rdSeen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bufRd) rdSeen++;
        end
        assertions++;
        if (rdSeen !== 0) begin failures++; $display("[TB] FAIL inflight_no_rd: got %0d reads expected 0", rdSeen); end
        #1;
        assertions++;
        if (rxCnt - start !== 1 || rxData[start] !== 48'h222222_111111 || rxLast[start] !== 1'b0 || rxUser[start] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL inflight_word: got beats=%0d data=%h last=%b user=%b expected beats=1 data=222222111111 last=0 user=0",
                     rxCnt - start, rxData[start], rxLast[start], rxUser[start]);
        end
        stepCycles(1);
        forceEmpty = 1'b1;
        pushA(48'h333333_444444);
        rdSeen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bufRd) rdSeen++;
        end
        assertions++;
        if (rdSeen !== 0) begin failures++; $display("[TB] FAIL held_empty_rd: got %0d reads expected 0", rdSeen); end
        stepCycles(1);
        forceEmpty = 1'b0;
        waitBeats(start + 2, 20);
        assertions++;
        if (rxCnt - start !== 2 || rxData[start + 1] !== 48'h444444_333333) begin
            failures++;
            $display("[TB] FAIL after_empty_word: got beats=%0d data=%h expected beats=2 data=444444333333", rxCnt - start, rxData[start + 1]);
        end
    endtask

    task automatic test_reset_mid_frame;
        int start;
        start = rxCnt;
        for (int i = 0; i < 6; i++) pushA({24'hDEAD00 + 24'(i), 24'hBEEF00 + 24'(i)});
        waitBeats(start + 1, 20);
        #2;
        rst_n = 1'b0;
        #1;
        assertions++;
        if ({tvalid, bufRd, tlast, tuser} !== 4'b0000 || tdata !== 48'h0) begin
            failures++;
            $display("[TB] FAIL async_reset: got valid/rd/last/user=%b data=%h expected 0000 data=0", {tvalid, bufRd, tlast, tuser}, tdata);
        end
        pushIdx = popIdx;
        stepCycles(2);
        rst_n = 1'b1;
        stepCycles(2);
        start = rxCnt;
        for (int i = 0; i < 6; i++) pushA({24'hF00000 + 24'(i), 24'h0F0000 + 24'(i)});
        waitBeats(start + 6, 30);
        for (int k = 0; k < 6; k++) begin
            assertions++;
            if (rxData[start + k] !== {24'h0F0000 + 24'(k), 24'hF00000 + 24'(k)} ||
                rxUser[start + k] !== (k == 0) || rxLast[start + k] !== (k == 5)) begin
                failures++;
                $display("[TB] FAIL post_reset_beat[%0d]: got data=%h user=%b last=%b expected user=%b last=%b",
                         k, rxData[start + k], rxUser[start + k], rxLast[start + k], k == 0, k == 5);
            end
        end
    endtask

    task automatic test_partial_last;
        logic [95:0] w [3];
        logic [95:0] gotData [3];
        logic [2:0]  gotLast;
        logic [2:0]  gotUser;
`ifdef AC_AXIS_TKEEP_EN
        logic [11:0] gotKeep [3];
        logic [11:0] expKeep [3];
        expKeep[0] = 12'hFFF;
        expKeep[1] = 12'hFFF;
        expKeep[2] = 12'h03F;
`endif
        int n;
        int fdB;
        n = 0;
        fdB = 0;
        gotLast = '0;
        gotUser = '0;
        for (int i = 0; i < 3; i++) begin
            w[i] = {24'h300000 + 24'(i), 24'h200000 + 24'(i), 24'h100000 + 24'(i), 24'h000000 + 24'(i)};
            gotData[i] = '0;
            memB[pushIdxB] = w[i];
            pushIdxB = pushIdxB + 4'd1;
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (tvalidB && treadyB && n < 3) begin
                gotData[n] = tdataB;
                gotLast[n] = tlastB;
                gotUser[n] = tuserB;
`ifdef AC_AXIS_TKEEP_EN
                gotKeep[n] = tkeepB;
`endif
                n++;
            end
            if (frameDoneB) fdB++;
        end
        assertions++;
        if (n !== 3 || fdB !== 1) begin failures++; $display("[TB] FAIL partial_count: got beats=%0d done=%0d expected 3 and 1", n, fdB); end
        for (int k = 0; k < 3; k++) begin
            assertions++;
            if (gotData[k] !== swap4(w[k]) || gotLast[k] !== (k == 2) || gotUser[k] !== (k == 0)) begin
                failures++;
                $display("[TB] FAIL partial_beat[%0d]: got data=%h last=%b user=%b expected data=%h last=%b user=%b",
                         k, gotData[k], gotLast[k], gotUser[k], swap4(w[k]), k == 2, k == 0);
            end
`ifdef AC_AXIS_TKEEP_EN
            assertions++;
            if (gotKeep[k] !== expKeep[k]) begin
                failures++;
                $display("[TB] FAIL partial_tkeep[%0d]: got %h expected %h", k, gotKeep[k], expKeep[k]);
            end
`endif
        end
    endtask

    initial begin
        $display("[TB] starting ac_axis_tx bench");
        test_reset;
        test_basic_frame;
        test_back_pressure;
        test_lane_reorder;
        test_empty_in_flight;
        test_reset_mid_frame;
        test_partial_last;
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
